// File: rtl/envelope_pkg.sv
// Shared constants for the PSG envelope generator: shape bit positions,
// RUN/HOLD state encoding and the step-counter maximum helper.
package envelope_pkg;

    localparam int SHAPE_HOLD   = 0;
    localparam int SHAPE_ALT    = 1;
    localparam int SHAPE_ATTACK = 2;
    localparam int SHAPE_CONT   = 3;

    localparam logic [0:0] ENV_RUN  = 1'b0;
    localparam logic [0:0] ENV_HOLD = 1'b1;

    function automatic int env_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/envelope_gen_if.sv
// Register-file / amplitude-mux side of the envelope generator.
// The master drives the shape, period and tick inputs; the slave returns amplitude and status.
interface envelope_gen_if #(
    parameter int PERIOD_BITS   = 16,
    parameter int ENVELOPE_BITS = 4
);
    logic                     enable;
    logic                     shape_we;
    logic [3:0]               shape;
    logic [PERIOD_BITS-1:0]   period;
    logic [ENVELOPE_BITS-1:0] out;
    logic                     holding;
    logic                     cycle_done;

    modport master (
        output enable, shape_we, shape, period,
        input  out, holding, cycle_done
    );

    modport slave (
        input  enable, shape_we, shape, period,
        output out, holding, cycle_done
    );
endinterface

// File: rtl/envelope_prescaler.sv
// Divides enable ticks down to one envelope step every max(period,1) ticks.
// step is combinational from the count and enable; clear restarts the count immediately, no backpressure.
module envelope_prescaler #(
    parameter int PERIOD_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [PERIOD_BITS-1:0] period,
    output logic                   step
);

    logic [PERIOD_BITS-1:0] count;
    logic [PERIOD_BITS-1:0] limit;

    // Period 0 behaves as 1; >= rather than == so a lowered period fires at once.
    assign limit = (period == '0) ? '0 : period - PERIOD_BITS'(1);
    assign step  = enable && (count >= limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count >= limit) begin
                count <= '0;
            end else begin
                count <= count + PERIOD_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/envelope_gen.sv
// PSG envelope generator: shape latch, RUN/HOLD step sequencer and inverting output mux.
// out/holding follow the registers with zero latency; cycle_done is a registered pulse; no backpressure.
module envelope_gen
    import envelope_pkg::*;
#(
    parameter int PERIOD_BITS   = 16,
    parameter int ENVELOPE_BITS = 4
) (
    input  logic           clk,
    input  logic           reset,
    envelope_gen_if.slave  bus
);

    localparam logic [ENVELOPE_BITS-1:0] MAX = ENVELOPE_BITS'(env_max(ENVELOPE_BITS));

    logic [3:0]               shape_q;
    logic [0:0]               state;
    logic                     invert;
    logic [ENVELOPE_BITS-1:0] counter;
    logic                     cycle_done_q;
    logic                     step;

    logic                     hold_l;
    logic                     alt_l;
    logic                     alt_eff;

    envelope_prescaler #(
        .PERIOD_BITS(PERIOD_BITS)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable),
        .clear  (bus.shape_we),
        .period (bus.period),
        .step   (step)
    );

    // Without continue the envelope always holds; a held envelope flips the sense
    // of alternate so the final level lands on the correct rail.
    always_comb begin
        hold_l  = shape_q[SHAPE_HOLD] | ~shape_q[SHAPE_CONT];
        alt_l   = shape_q[SHAPE_CONT] ? shape_q[SHAPE_ALT] : shape_q[SHAPE_ATTACK];
        alt_eff = hold_l ? ~alt_l : alt_l;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shape_q      <= 4'b0000;
            state        <= ENV_HOLD;
            counter      <= '0;
            invert       <= 1'b0;
            cycle_done_q <= 1'b0;
        end else if (bus.shape_we) begin
            shape_q      <= bus.shape;
            state        <= ENV_RUN;
            counter      <= '0;
            invert       <= ~bus.shape[SHAPE_ATTACK];
            cycle_done_q <= 1'b0;
        end else begin
            cycle_done_q <= 1'b0;
            if (state == ENV_RUN && step) begin
                if (counter == MAX) begin
                    counter      <= '0;
                    cycle_done_q <= 1'b1;
                    if (alt_eff) begin
                        invert <= ~invert;
                    end
                    if (hold_l) begin
                        state <= ENV_HOLD;
                    end
                end else begin
                    counter <= counter + ENVELOPE_BITS'(1);
                end
            end
        end
    end

    assign bus.out        = invert ? (MAX - counter) : counter;
    assign bus.holding    = (state == ENV_HOLD);
    assign bus.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_envelope_gen.sv
module tb_envelope_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    envelope_gen_if #(.PERIOD_BITS(16), .ENVELOPE_BITS(4)) bus4 ();
    envelope_gen_if #(.PERIOD_BITS(16), .ENVELOPE_BITS(5)) bus5 ();

    envelope_gen #(.PERIOD_BITS(16), .ENVELOPE_BITS(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    envelope_gen #(.PERIOD_BITS(16), .ENVELOPE_BITS(5)) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write4(input logic [3:0] s);
        bus4.shape    = s;
        bus4.shape_we = 1'b1;
        tick();
        bus4.shape_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors += 5;
        if (bus4.out !== 4'd0) begin miscompares++; $display("FAIL reset_out4: got %0d want 0", bus4.out); end
        if (bus4.holding !== 1'b1) begin miscompares++; $display("FAIL reset_holding4: got %b want 1", bus4.holding); end
        if (bus4.cycle_done !== 1'b0) begin miscompares++; $display("FAIL reset_cd4: got %b want 0", bus4.cycle_done); end
        if (bus5.out !== 5'd0) begin miscompares++; $display("FAIL reset_out5: got %0d want 0", bus5.out); end
        if (bus5.holding !== 1'b1) begin miscompares++; $display("FAIL reset_holding5: got %b want 1", bus5.holding); end
        reset = 1'b0;
        tick();
        vectors++;
        if (bus4.out !== 4'd0 || bus4.holding !== 1'b1) begin
            miscompares++; $display("FAIL silent_after_reset: out=%0d holding=%b want 0/1", bus4.out, bus4.holding);
        end
    endtask

    task automatic test_saw_down();
        bus4.period = 16'd1;
        bus4.enable = 1'b1;
        write4(4'b1000);
        vectors++;
        if (bus4.out !== 4'd15) begin miscompares++; $display("FAIL saw_start: got %0d want 15", bus4.out); end
        for (int i = 1; i <= 40; i++) begin
            tick();
            vectors += 3;
            if (bus4.out !== 4'(15 - (i % 16))) begin
                miscompares++; $display("FAIL saw_out[%0d]: got %0d want %0d", i, bus4.out, 15 - (i % 16));
            end
            if (bus4.cycle_done !== ((i % 16) == 0)) begin
                miscompares++; $display("FAIL saw_cd[%0d]: got %b want %b", i, bus4.cycle_done, (i % 16) == 0);
            end
            if (bus4.holding !== 1'b0) begin
                miscompares++; $display("FAIL saw_holding[%0d]: got %b want 0", i, bus4.holding);
            end
        end
    endtask

    task automatic test_triangle();
        int p;
        int e;
        bus4.period = 16'd2;
        write4(4'b1110);
        vectors++;
        if (bus4.out !== 4'd0) begin miscompares++; $display("FAIL tri_start: got %0d want 0", bus4.out); end
        for (int i = 1; i <= 70; i++) begin
            tick();
            p = (i / 2) % 32;
            e = (p < 16) ? p : 31 - p;
            vectors += 2;
            if (bus4.out !== 4'(e)) begin
                miscompares++; $display("FAIL tri_out[%0d]: got %0d want %0d", i, bus4.out, e);
            end
            if (bus4.cycle_done !== ((i % 2 == 0) && ((i / 2) % 16 == 0))) begin
                miscompares++; $display("FAIL tri_cd[%0d]: got %b", i, bus4.cycle_done);
            end
        end
    endtask

    task automatic test_hold_high();
        bus4.period = 16'd1;
        write4(4'b1011);
        vectors++;
        if (bus4.out !== 4'd15) begin miscompares++; $display("FAIL hh_start: got %0d want 15", bus4.out); end
        for (int i = 1; i <= 30; i++) begin
            tick();
            vectors += 3;
            if (bus4.out !== 4'((i < 16) ? 15 - i : 15)) begin
                miscompares++; $display("FAIL hh_out[%0d]: got %0d want %0d", i, bus4.out, (i < 16) ? 15 - i : 15);
            end
            if (bus4.holding !== (i >= 16)) begin
                miscompares++; $display("FAIL hh_holding[%0d]: got %b want %b", i, bus4.holding, i >= 16);
            end
            if (bus4.cycle_done !== (i == 16)) begin
                miscompares++; $display("FAIL hh_cd[%0d]: got %b want %b", i, bus4.cycle_done, i == 16);
            end
        end
    endtask

    task automatic test_attack_hold_p0();
        bus4.period = 16'd0;
        write4(4'b0100);
        vectors++;
        if (bus4.out !== 4'd0) begin miscompares++; $display("FAIL ah_start: got %0d want 0", bus4.out); end
        for (int i = 1; i <= 30; i++) begin
            tick();
            vectors += 3;
            if (bus4.out !== 4'((i < 16) ? i : 0)) begin
                miscompares++; $display("FAIL ah_out[%0d]: got %0d want %0d", i, bus4.out, (i < 16) ? i : 0);
            end
            if (bus4.holding !== (i >= 16)) begin
                miscompares++; $display("FAIL ah_holding[%0d]: got %b want %b", i, bus4.holding, i >= 16);
            end
            if (bus4.cycle_done !== (i == 16)) begin
                miscompares++; $display("FAIL ah_cd[%0d]: got %b want %b", i, bus4.cycle_done, i == 16);
            end
        end
    endtask

    task automatic test_ym_saw();
        bus5.period   = 16'd1;
        bus5.enable   = 1'b1;
        bus5.shape    = 4'b1100;
        bus5.shape_we = 1'b1;
        tick();
        bus5.shape_we = 1'b0;
        vectors++;
        if (bus5.out !== 5'd0) begin miscompares++; $display("FAIL ym_start: got %0d want 0", bus5.out); end
        for (int i = 1; i <= 70; i++) begin
            tick();
            vectors += 2;
            if (bus5.out !== 5'(i % 32)) begin
                miscompares++; $display("FAIL ym_out[%0d]: got %0d want %0d", i, bus5.out, i % 32);
            end
            if (bus5.cycle_done !== ((i % 32) == 0)) begin
                miscompares++; $display("FAIL ym_cd[%0d]: got %b want %b", i, bus5.cycle_done, (i % 32) == 0);
            end
        end
    endtask

    task automatic test_period_change();
        bus4.period = 16'd8;
        write4(4'b1100);
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++;
            if (bus4.out !== 4'd0) begin miscompares++; $display("FAIL pc_wait[%0d]: got %0d want 0", i, bus4.out); end
        end
        bus4.period = 16'd2;
        tick();
        vectors++;
        if (bus4.out !== 4'd1) begin miscompares++; $display("FAIL pc_fire: got %0d want 1", bus4.out); end
        tick();
        vectors++;
        if (bus4.out !== 4'd1) begin miscompares++; $display("FAIL pc_gap: got %0d want 1", bus4.out); end
        tick();
        vectors++;
        if (bus4.out !== 4'd2) begin miscompares++; $display("FAIL pc_next: got %0d want 2", bus4.out); end
    endtask

    task automatic test_back_to_back();
        bus4.period = 16'd1;
        write4(4'b1000);
        repeat (7) tick();
        vectors++;
        if (bus4.out !== 4'd8) begin miscompares++; $display("FAIL b2b_pre: got %0d want 8", bus4.out); end
        write4(4'b1000);
        vectors += 3;
        if (bus4.out !== 4'd15) begin miscompares++; $display("FAIL b2b_rewrite_out: got %0d want 15", bus4.out); end
        if (bus4.cycle_done !== 1'b0) begin miscompares++; $display("FAIL b2b_rewrite_cd: got %b want 0", bus4.cycle_done); end
        if (bus4.holding !== 1'b0) begin miscompares++; $display("FAIL b2b_rewrite_holding: got %b want 0", bus4.holding); end
        repeat (15) tick();
        vectors++;
        if (bus4.out !== 4'd0) begin miscompares++; $display("FAIL b2b_at_max: got %0d want 0", bus4.out); end
        // Rewrite on the wrapping cycle: write must win, no wrap pulse.
        write4(4'b1110);
        vectors += 2;
        if (bus4.out !== 4'd0) begin miscompares++; $display("FAIL wrap_rewrite_out: got %0d want 0", bus4.out); end
        if (bus4.cycle_done !== 1'b0) begin miscompares++; $display("FAIL wrap_rewrite_cd: got %b want 0", bus4.cycle_done); end
        repeat (3) tick();
        vectors++;
        if (bus4.out !== 4'd3) begin miscompares++; $display("FAIL en_pre: got %0d want 3", bus4.out); end
        bus4.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (bus4.out !== 4'd3 || bus4.cycle_done !== 1'b0) begin
                miscompares++; $display("FAIL en_frozen[%0d]: out=%0d cd=%b want 3/0", i, bus4.out, bus4.cycle_done);
            end
        end
        write4(4'b1000);
        vectors++;
        if (bus4.out !== 4'd15) begin miscompares++; $display("FAIL en_off_write: got %0d want 15", bus4.out); end
        tick();
        vectors++;
        if (bus4.out !== 4'd15) begin miscompares++; $display("FAIL en_off_hold: got %0d want 15", bus4.out); end
        bus4.enable = 1'b1;
        tick();
        vectors++;
        if (bus4.out !== 4'd14) begin miscompares++; $display("FAIL en_resume: got %0d want 14", bus4.out); end
        reset         = 1'b1;
        bus4.shape    = 4'b1110;
        bus4.shape_we = 1'b1;
        tick();
        reset         = 1'b0;
        bus4.shape_we = 1'b0;
        vectors += 3;
        if (bus4.out !== 4'd0) begin miscompares++; $display("FAIL rst_mid_out: got %0d want 0", bus4.out); end
        if (bus4.holding !== 1'b1) begin miscompares++; $display("FAIL rst_mid_holding: got %b want 1", bus4.holding); end
        if (bus4.cycle_done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_cd: got %b want 0", bus4.cycle_done); end
        repeat (5) tick();
        vectors++;
        if (bus4.out !== 4'd0 || bus4.holding !== 1'b1) begin
            miscompares++; $display("FAIL rst_silent: out=%0d holding=%b want 0/1", bus4.out, bus4.holding);
        end
    endtask

    initial begin
        bus4.enable   = 1'b0;
        bus4.shape_we = 1'b0;
        bus4.shape    = 4'b0000;
        bus4.period   = 16'd1;
        bus5.enable   = 1'b0;
        bus5.shape_we = 1'b0;
        bus5.shape    = 4'b0000;
        bus5.period   = 16'd1;
        test_reset();
        test_saw_down();
        test_triangle();
        test_hold_high();
        test_attack_hold_p0();
        test_ym_saw();
        test_period_change();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
